// File: rtl/ext_mem_responder.sv
// ext_mem_responder: byte memory filled by a streaming loader, then served to a uC over a shared tristate bus.
// Optional write protection of the low address region is enabled with MEM_WRITE_PROTECT_EN.
module ext_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
`ifdef MEM_WRITE_PROTECT_EN
  , parameter logic [ADDR_WIDTH-1:0] WP_LIMIT = ADDR_WIDTH'('h80)
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_write_en,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  load_start,
  output logic                  load_ready,
  output logic                  cpu_rst,
`ifdef MEM_WRITE_PROTECT_EN
  output logic                  wp_violation,
`endif
  output logic [ADDR_WIDTH:0]   load_count
);
  typedef enum logic {LOAD, RUN} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic                  w_load;
  logic                  w_store_req;
  logic                  w_store;
  assign w_load      = !rst && r_state == LOAD && load_valid;
  assign w_store_req = !rst && r_state == RUN && mem_write_en;
`ifdef MEM_WRITE_PROTECT_EN
  logic w_wp_hit;
  assign w_wp_hit = w_store_req && mem_addr < WP_LIMIT;
  assign w_store  = w_store_req && !w_wp_hit;
`else
  assign w_store  = w_store_req;
`endif
  assign load_ready = rst || r_state == LOAD;
  assign cpu_rst    = rst || r_state == LOAD;
  assign load_count = r_count;
  assign mem_data   = (!rst && r_state == RUN && !mem_write_en) ? r_mem[mem_addr] : 'z;
  // Memory has no reset so its contents survive rst and partial reloads.
  always_ff @(posedge clk) begin
    if (w_load) r_mem[r_ptr] <= load_data;
    else if (w_store) r_mem[mem_addr] <= mem_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_ptr   <= '0;
      r_count <= '0;
`ifdef MEM_WRITE_PROTECT_EN
      wp_violation <= 1'b0;
`endif
    end else begin
`ifdef MEM_WRITE_PROTECT_EN
      wp_violation <= w_wp_hit;
`endif
      if (r_state == LOAD) begin
        if (load_valid) begin
          r_ptr   <= r_ptr + 1'b1;
          r_count <= r_count + 1'b1;
          if (load_last || &r_ptr) r_state <= RUN;
        end
      end else if (load_start) begin
        r_state <= LOAD;
        r_ptr   <= '0;
        r_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder: scoreboard bench for ext_mem_responder (reads checked against a model memory).
module tb_ext_mem_responder;
  localparam int AW = 8;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst, we, lv, ll, ls, drv_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] ld, drv;
  wire  [DW-1:0] mem_data;
  logic lr, crst;
  logic [AW:0] lc;
`ifdef MEM_WRITE_PROTECT_EN
  logic wp;
`endif
  int errs = 0;
  int checks = 0;
  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] exp_q [$];
  assign mem_data = drv_en ? drv : 'z;
  always #5 clk = ~clk;
  ext_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_write_en(we), .mem_data(mem_data),
    .load_valid(lv), .load_data(ld), .load_last(ll), .load_start(ls),
    .load_ready(lr), .cpu_rst(crst),
`ifdef MEM_WRITE_PROTECT_EN
    .wp_violation(wp),
`endif
    .load_count(lc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    we = 0; lv = 0; ll = 0; ls = 0; drv_en = 0;
  endtask
  task automatic load_byte(input int a, input logic [DW-1:0] d, input logic last);
    lv = 1; ld = d; ll = last;
    tick;
    model[a] = d;
    lv = 0; ll = 0;
  endtask
  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lands);
    we = 1; addr = a; drv = d; drv_en = 1;
    tick;
    if (lands) model[a] = d;
    idle;
  endtask
  task automatic rd(input string tag, input logic [AW-1:0] a);
    we = 0; drv_en = 0; addr = a;
    exp_q.push_back(model[a]);
    #1;
    chk(tag, mem_data, exp_q.pop_front());
  endtask
  initial begin
    idle; rst = 1; addr = 0; ld = 0; drv = 0;
    tick; tick;
    chk("rst_ready", lr, 1); chk("rst_cpu_rst", crst, 1); chk("rst_count", lc, 0);
    rst = 0;
    tick; tick;
    chk("zero_len_stay", crst, 1);
    // Test 1: four-byte load ending on load_last
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("t1_pre_last", crst, 1);
      load_byte(i, DW'((i + 1) * 16), i == 3);
    end
    chk("t1_count", lc, 4); chk("t1_cpu_rst", crst, 0); chk("t1_ready", lr, 0);
    addr = 2; #1;
    chk("t1_rd2_const", mem_data, 8'h30);
    rd("t1_rd0", 0);
    // Test 2: stores in RUN, bus released during store
    store(8'hC3, 8'h5A, 1);
    we = 1; addr = 8'hC3; drv = 8'hA5; drv_en = 1;
    #1;
    chk("t2_hiz", mem_data, 8'hA5);
    tick; model[8'hC3] = 8'hA5; idle;
    rd("t2_rd", 8'hC3);
    // Test 3: full 256-byte stream auto-terminates
    ls = 1; tick; ls = 0;
    chk("t3_reload_cnt", lc, 0); chk("t3_reload_crst", crst, 1);
    for (int i = 0; i < 256; i++) begin
      ls = (i == 10);
      if (i == 255) chk("t3_pre_last", crst, 1);
      load_byte(i, DW'(i) ^ 8'h3C, 0);
    end
    ls = 0;
    chk("t3_count", lc, 256); chk("t3_cpu_rst", crst, 0);
    lv = 1; ld = 8'hFF; tick; tick; lv = 0;
    chk("t3_ignored_cnt", lc, 256);
    rd("t3_rd0", 0); rd("t3_rd255", 255); rd("t3_rd2", 2);
    // Test 4: reset aborts a load mid-stream
    ls = 1; tick; ls = 0;
    for (int i = 0; i < 3; i++) load_byte(i, 8'hB0 + DW'(i), 0);
    rst = 1; lv = 1; ld = 8'hEE;
    #1;
    chk("t4_rst_ready", lr, 1);
    tick; rst = 0; lv = 0;
    chk("t4_rst_count", lc, 0);
    load_byte(0, 8'hD0, 0);
    load_byte(1, 8'hD1, 1);
    chk("t4_count", lc, 2); chk("t4_cpu_rst", crst, 0);
    rd("t4_rd0", 0); rd("t4_rd1", 1); rd("t4_rd2", 2); rd("t4_rd3", 3);
    // Test 5: load_start coinciding with a uC store
    we = 1; addr = 8'h90; drv = 8'h55; drv_en = 1; ls = 1;
    tick; model[8'h90] = 8'h55; idle;
    chk("t5_cpu_rst", crst, 1); chk("t5_count", lc, 0); chk("t5_ready", lr, 1);
    we = 1; addr = 8'h91; drv = 8'h11; drv_en = 1;
    #1;
    chk("t5_load_hiz", mem_data, 8'h11);
    tick; idle;
    load_byte(0, 8'h01, 1);
    rd("t5_rd90", 8'h90); rd("t5_rd91", 8'h91); rd("t5_rd0", 0);
`ifdef MEM_WRITE_PROTECT_EN
    // Test 6: protected low region
    chk("t6_wp_idle", wp, 0);
    store(8'h05, 8'h77, 0);
    chk("t6_wp_pulse", wp, 1);
    tick;
    chk("t6_wp_clear", wp, 0);
    store(8'h80, 8'h66, 1);
    chk("t6_wp_none", wp, 0);
    rd("t6_rd05", 8'h05); rd("t6_rd80", 8'h80);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
